// File: rtl/pipe_regfile_if.sv
// rtl/pipe_regfile_if.sv - write-back, operand-read and debug-read bus of the ID-stage register file
interface pipe_regfile_if #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int CNTW = 16
);
   logic            we;
   logic [AW-1:0]   wn;
   logic [DW-1:0]   wd;
   logic [AW-1:0]   rna;
   logic [AW-1:0]   rnb;
   logic [DW-1:0]   qa;
   logic [DW-1:0]   qb;
   logic [AW-1:0]   dbg_rn;
   logic [DW-1:0]   dbg_q;
   logic [CNTW-1:0] wr_cnt;

   modport master (
      output we, wn, wd, rna, rnb, dbg_rn,
      input  qa, qb, dbg_q, wr_cnt
   );

   modport slave (
      input  we, wn, wd, rna, rnb, dbg_rn,
      output qa, qb, dbg_q, wr_cnt
   );
endinterface

// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - 32-entry GPR file with two operand reads, registered debug read and write counter
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through from wd onto qa/qb.
module pipe_regfile #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   pipe_regfile_if.slave   bus
);
   localparam int NREG = 2 ** AW;

   logic [DW-1:0]   mem [NREG];
   logic [DW-1:0]   dbg_q_r;
   logic [CNTW-1:0] wr_cnt_r;
   logic [DW-1:0]   qa_v;
   logic [DW-1:0]   qb_v;
   logic            wr_commit;

   // r0 is never written, so it stays at its reset value of zero
   assign wr_commit = bus.we && (bus.wn != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_commit) begin
         mem[bus.wn] <= bus.wd;
      end
   end

   // Debug read samples the pre-write contents of the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_q_r <= '0;
      end else if (bus.dbg_rn == '0) begin
         dbg_q_r <= '0;
      end else begin
         dbg_q_r <= mem[bus.dbg_rn];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_r <= '0;
      end else if (wr_commit) begin
         wr_cnt_r <= wr_cnt_r + 1'b1;
      end
   end

   always_comb begin
      qa_v = mem[bus.rna];
      qb_v = mem[bus.rnb];
`ifdef REGFILE_BYPASS_EN
      if (wr_commit && (bus.rna == bus.wn)) qa_v = bus.wd;
      if (wr_commit && (bus.rnb == bus.wn)) qb_v = bus.wd;
`endif
      if (bus.rna == '0) qa_v = '0;
      if (bus.rnb == '0) qb_v = '0;
   end

   assign bus.qa     = qa_v;
   assign bus.qb     = qb_v;
   assign bus.dbg_q  = dbg_q_r;
   assign bus.wr_cnt = wr_cnt_r;
endmodule

// File: tb/tb_pipe_regfile.sv
// tb/tb_pipe_regfile.sv - scoreboard bench for pipe_regfile (4-bit counter build to reach the wrap)
module tb_pipe_regfile;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int CNTW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   pipe_regfile_if #(.DW(DW), .AW(AW), .CNTW(CNTW)) bus ();

   pipe_regfile #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] model_mem [32];
   int model_cnt = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp;

   function automatic logic [CNTW-1:0] cnt_exp();
      return CNTW'(model_cnt);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      model_cnt = 0;
   endtask

   task automatic wr(input logic [AW-1:0] n, input logic [DW-1:0] d);
      @(negedge clk);
      bus.we = 1'b1; bus.wn = n; bus.wd = d;
      @(posedge clk); #1;
      bus.we = 1'b0;
      if (n != 0) begin
         model_mem[n] = d;
         model_cnt++;
      end
   endtask

   task automatic test_reset();
      bus.we = 1'b0; bus.wn = '0; bus.wd = '0;
      bus.rna = 5'd5; bus.rnb = 5'd6; bus.dbg_rn = '0;
      model_clear();
      #2 rst_n = 1'b0;
      #1;
      exp_q.push_back('0);
      exp = exp_q.pop_front(); checks++;
      if (bus.qa !== exp) begin errors++; $display("FAIL reset_qa got %h want %h", bus.qa, exp); end
      exp_q.push_back('0);
      exp = exp_q.pop_front(); checks++;
      if (bus.qb !== exp) begin errors++; $display("FAIL reset_qb got %h want %h", bus.qb, exp); end
      exp_q.push_back('0);
      exp = exp_q.pop_front(); checks++;
      if (bus.dbg_q !== exp) begin errors++; $display("FAIL reset_dbg_q got %h want %h", bus.dbg_q, exp); end
      checks++;
      if (bus.wr_cnt !== cnt_exp()) begin errors++; $display("FAIL reset_wr_cnt got %0d want %0d", bus.wr_cnt, cnt_exp()); end
      // a write presented across an edge while reset is held must be dropped
      bus.we = 1'b1; bus.wn = 5'd5; bus.wd = 32'hBAD0BAD0;
      @(posedge clk); @(negedge clk);
      bus.we = 1'b0;
      #2 rst_n = 1'b1;
      #1;
      exp_q.push_back(model_mem[5]);
      exp = exp_q.pop_front(); checks++;
      if (bus.qa !== exp) begin errors++; $display("FAIL reset_write_dropped got %h want %h", bus.qa, exp); end
      checks++;
      if (bus.wr_cnt !== cnt_exp()) begin errors++; $display("FAIL reset_write_cnt got %0d want %0d", bus.wr_cnt, cnt_exp()); end
   endtask

   task automatic test_basic();
      wr(5'd5, 32'hDEADBEEF);
      bus.rna = 5'd5; bus.rnb = 5'd5;
      #1;
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'hDEADBEEF);
      exp = exp_q.pop_front(); checks++;
      if (bus.qa !== exp) begin errors++; $display("FAIL basic_qa got %h want %h", bus.qa, exp); end
      exp = exp_q.pop_front(); checks++;
      if (bus.qb !== exp) begin errors++; $display("FAIL basic_qb got %h want %h", bus.qb, exp); end
      checks++;
      if (bus.wr_cnt !== CNTW'(1)) begin errors++; $display("FAIL basic_wr_cnt got %0d want 1", bus.wr_cnt); end
   endtask

   task automatic test_r0();
      wr(5'd0, 32'hFFFFFFFF);
      bus.rna = 5'd0; bus.rnb = 5'd0;
      #1;
      exp_q.push_back('0);
      exp = exp_q.pop_front(); checks++;
      if (bus.qa !== exp) begin errors++; $display("FAIL r0_qa got %h want %h", bus.qa, exp); end
      checks++;
      if (bus.wr_cnt !== cnt_exp()) begin errors++; $display("FAIL r0_wr_cnt got %0d want %0d", bus.wr_cnt, cnt_exp()); end
      // r0 stays zero even while a write to r0 is being presented
      @(negedge clk);
      bus.we = 1'b1; bus.wn = 5'd0; bus.wd = 32'h13572468;
      #1;
      exp_q.push_back('0);
      exp = exp_q.pop_front(); checks++;
      if (bus.qb !== exp) begin errors++; $display("FAIL r0_live_qb got %h want %h", bus.qb, exp); end
      @(posedge clk); #1;
      bus.we = 1'b0;
   endtask

   task automatic test_bypass();
      wr(5'd7, 32'h1);
      @(negedge clk);
      bus.we = 1'b1; bus.wn = 5'd7; bus.wd = 32'h12345678;
      bus.rna = 5'd7; bus.rnb = 5'd7;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back(32'h12345678);
`else
      exp_q.push_back(32'h1);
`endif
      exp = exp_q.pop_front(); checks++;
      if (bus.qa !== exp) begin errors++; $display("FAIL bypass_pre_edge_qa got %h want %h", bus.qa, exp); end
      @(posedge clk); #1;
      bus.we = 1'b0;
      model_mem[7] = 32'h12345678; model_cnt++;
      exp_q.push_back(32'h12345678);
      exp = exp_q.pop_front(); checks++;
      if (bus.qa !== exp) begin errors++; $display("FAIL bypass_post_edge_qa got %h want %h", bus.qa, exp); end
   endtask

   task automatic test_debug();
      wr(5'd9, 32'hA5A5A5A5);
      @(negedge clk);
      bus.dbg_rn = 5'd9; exp_q.push_back(model_mem[9]);
      @(posedge clk); #1;
      exp = exp_q.pop_front(); checks++;
      if (bus.dbg_q !== exp) begin errors++; $display("FAIL dbg_r9 got %h want %h", bus.dbg_q, exp); end
      @(negedge clk);
      bus.dbg_rn = 5'd0; exp_q.push_back('0);
      @(posedge clk); #1;
      exp = exp_q.pop_front(); checks++;
      if (bus.dbg_q !== exp) begin errors++; $display("FAIL dbg_r0 got %h want %h", bus.dbg_q, exp); end
      // same-edge write to the debugged register appears one cycle later
      @(negedge clk);
      bus.dbg_rn = 5'd9; bus.we = 1'b1; bus.wn = 5'd9; bus.wd = 32'h0F0F0F0F;
      exp_q.push_back(model_mem[9]);
      @(posedge clk); #1;
      bus.we = 1'b0;
      model_mem[9] = 32'h0F0F0F0F; model_cnt++;
      exp = exp_q.pop_front(); checks++;
      if (bus.dbg_q !== exp) begin errors++; $display("FAIL dbg_same_edge got %h want %h", bus.dbg_q, exp); end
      exp_q.push_back(model_mem[9]);
      @(posedge clk); #1;
      exp = exp_q.pop_front(); checks++;
      if (bus.dbg_q !== exp) begin errors++; $display("FAIL dbg_next_edge got %h want %h", bus.dbg_q, exp); end
      bus.dbg_rn = 5'd0;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      model_clear();
      for (int i = 0; i < 16; i++) begin
         wr(5'd3, DW'(i + 100));
         checks++;
         if (bus.wr_cnt !== cnt_exp()) begin errors++; $display("FAIL wrap_cnt step %0d got %0d want %0d", i, bus.wr_cnt, cnt_exp()); end
      end
      for (int i = 0; i < 5; i++) wr(5'd3, DW'(i));
      bus.rna = 5'd3;
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (bus.wr_cnt !== cnt_exp()) begin errors++; $display("FAIL wrap_reset_cnt got %0d want %0d", bus.wr_cnt, cnt_exp()); end
      exp_q.push_back(model_mem[3]);
      exp = exp_q.pop_front(); checks++;
      if (bus.qa !== exp) begin errors++; $display("FAIL wrap_reset_qa got %h want %h", bus.qa, exp); end
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [AW-1:0] a, b;
      for (int i = 0; i < 60; i++) begin
         wr(AW'($urandom_range(0, 31)), $urandom());
         a = AW'($urandom_range(0, 31));
         b = (i % 4 == 0) ? a : AW'($urandom_range(0, 31));
         bus.rna = a; bus.rnb = b;
         #1;
         exp_q.push_back(model_mem[a]);
         exp_q.push_back(model_mem[b]);
         exp = exp_q.pop_front(); checks++;
         if (bus.qa !== exp) begin errors++; $display("FAIL rand_qa r%0d got %h want %h", a, bus.qa, exp); end
         exp = exp_q.pop_front(); checks++;
         if (bus.qb !== exp) begin errors++; $display("FAIL rand_qb r%0d got %h want %h", b, bus.qb, exp); end
      end
      checks++;
      if (bus.wr_cnt !== cnt_exp()) begin errors++; $display("FAIL rand_wr_cnt got %0d want %0d", bus.wr_cnt, cnt_exp()); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_r0();
      test_bypass();
      test_debug();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
